// File: rtl/seg7_count_scanner_if.sv
// seg7_count_scanner_if: display-path bundle between a counter source and the 7-segment scanner.
//   value/load/freeze/blank_lz : driven by the master (source/controls)
//   shown/an/seg/dp            : driven by the slave (scanner)
interface seg7_count_scanner_if;
    logic [31:0] value;
    logic        load;
    logic        freeze;
    logic        blank_lz;
    logic [31:0] shown;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    modport master (output value, load, freeze, blank_lz, input shown, an, seg, dp);
    modport slave  (input value, load, freeze, blank_lz, output shown, an, seg, dp);
endinterface

// File: rtl/seg7_count_scanner.sv
// seg7_count_scanner: snapshots a 32-bit count and scans it as 8 hex digits on a common-anode display.
//   clk, rst_n (async active-low)
//   bus.value/load/freeze/blank_lz in; bus.shown (snapshot), bus.an/seg/dp (active-low display) out
module seg7_count_scanner #(
    parameter int SCAN_DIV = 100000,
    parameter int PRE_W    = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_count_scanner_if.slave   bus
);
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shown_q, shown_d;
    logic [31:0]      upper;
    logic [3:0]       nib;
    logic [6:0]       dec;
    logic             wrap, lz;
    always_comb begin
        wrap    = pre_q == PRE_W'(SCAN_DIV - 1);
        pre_d   = wrap ? '0 : pre_q + 1'b1;
        idx_d   = wrap ? idx_q + 3'd1 : idx_q;
        shown_d = (bus.load && !bus.freeze) ? bus.value : shown_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            idx_q   <= '0;
            shown_q <= '0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            shown_q <= shown_d;
        end
    end
    always_comb begin
        upper = shown_q >> {idx_q, 2'b00};
        nib   = shown_q[{idx_q, 2'b00} +: 4];
        lz    = bus.blank_lz && idx_q != 3'd0 && upper == 32'd0;
        case (nib)
            4'h0: dec = 7'h40;
            4'h1: dec = 7'h79;
            4'h2: dec = 7'h24;
            4'h3: dec = 7'h30;
            4'h4: dec = 7'h19;
            4'h5: dec = 7'h12;
            4'h6: dec = 7'h02;
            4'h7: dec = 7'h78;
            4'h8: dec = 7'h00;
            4'h9: dec = 7'h10;
            4'hA: dec = 7'h08;
            4'hB: dec = 7'h03;
            4'hC: dec = 7'h46;
            4'hD: dec = 7'h21;
            4'hE: dec = 7'h06;
            default: dec = 7'h0E;
        endcase
    end
    assign bus.shown = shown_q;
    assign bus.an    = ~(8'b1 << idx_q);
    assign bus.seg   = lz ? 7'h7F : dec;
    // rst_n gating keeps the frozen indicator dark while held in reset
    assign bus.dp    = !(idx_q == 3'd0 && bus.freeze && rst_n);
endmodule

// File: tb/tb_seg7_count_scanner.sv
// tb_seg7_count_scanner: directed + random checks of the scanner against a frame-timing reference model.
module tb_seg7_count_scanner;
    localparam int SD = 4;
    logic clk = 0;
    logic rst_n = 0;
    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    logic [31:0] m_shown = 0;
    logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    seg7_count_scanner_if bus ();
    seg7_count_scanner #(.SCAN_DIV(SD), .PRE_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected display derived from elapsed cycles and digit arithmetic on the snapshot
    task automatic check_all();
        int idx;
        longint div;
        longint hi;
        logic [6:0] es;
        idx = (cyc / SD) % 8;
        div = 1;
        for (int i = 0; i < idx; i++) div = div * 16;
        hi = longint'(m_shown) / div;
        es = (bus.blank_lz && idx != 0 && hi == 0) ? 7'h7F : hex_tab[hi % 16];
        chk("an", {24'd0, bus.an}, {24'd0, an_tab[idx]});
        chk("seg", {25'd0, bus.seg}, {25'd0, es});
        chk("dp", {31'd0, bus.dp}, {31'd0, !(idx == 0 && bus.freeze)});
        chk("shown", bus.shown, m_shown);
    endtask

    task automatic tick();
        @(posedge clk);
        if (bus.load && !bus.freeze) m_shown = bus.value;
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic load_val(input logic [31:0] v);
        bus.value = v;
        bus.load = 1;
        tick();
        bus.load = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_an"}, {24'd0, bus.an}, 32'hFE);
        chk({tag, "_seg"}, {25'd0, bus.seg}, 32'h40);
        chk({tag, "_dp"}, {31'd0, bus.dp}, 32'h1);
        chk({tag, "_shown"}, bus.shown, 32'h0);
    endtask

    initial begin
        bus.value = 32'hDEAD_BEEF;
        bus.load = 0;
        bus.freeze = 0;
        bus.blank_lz = 0;
        #2;
        check_reset("rst_hold");
        @(negedge clk);
        rst_n = 1;
        cyc = 0;
        m_shown = 0;
        check_all();
        // Test 1: async reset mid-scan, then a full first slot
        load_val(32'h1234_5678);
        repeat (9) tick();
        #2 rst_n = 0;
        #1 check_reset("rst_async");
        @(negedge clk);
        rst_n = 1;
        cyc = 0;
        m_shown = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_slot_an", {24'd0, bus.an}, 32'hFD);
        // Test 2: full scan and wrap
        load_val(32'h89AB_CDEF);
        repeat (40) tick();
        // Test 3: blanking
        bus.blank_lz = 1;
        load_val(32'h0000_00A5);
        repeat (32) tick();
        load_val(32'h0);
        repeat (32) tick();
        bus.blank_lz = 0;
        // Test 4: freeze blocks load, no queuing
        load_val(32'h12);
        bus.freeze = 1;
        load_val(32'h34);
        repeat (32) tick();
        chk("frz_hold", bus.shown, 32'h12);
        bus.freeze = 0;
        repeat (5) tick();
        chk("frz_noqueue", bus.shown, 32'h12);
        load_val(32'h34);
        chk("frz_load", bus.shown, 32'h34);
        // Test 5: load coincident with idx0 -> idx1 advance
        for (int i = 0; i < 40 && (cyc % (8 * SD)) != SD - 1; i++) tick();
        chk("coin_align", cyc % (8 * SD), SD - 1);
        load_val(32'h7);
        chk("coin_an", {24'd0, bus.an}, 32'hFD);
        chk("coin_shown", bus.shown, 32'h7);
        repeat (31) tick();
        chk("coin_seg0", {25'd0, bus.seg}, 32'h78);
        // Random phase
        for (int i = 0; i < 400; i++) begin
            bus.value = $urandom;
            if ($urandom_range(0, 3) == 0) bus.value = bus.value >> (4 * $urandom_range(0, 8));
            bus.load = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) bus.freeze = ~bus.freeze;
            if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
